fifo_flex: RTL and testbench
============================

// Module: fifo_flex
// PURPOSE
//  Parametrised synchronous FIFO. Successor to the fixed 8-bit/32-entry FIFO.
//  Adds configurable data width, occupancy count, sticky overflow/underflow flags,
//  synchronous flush and simultaneous push-on-full. Optional first-word fall-through.
//  Instantiated inside tt_um_* wrappers; ui_in/uio_in drive data and controls, uo_out/uio_out carry results.
// PARAMETERS
//  DATA_WIDTH              8   bits per entry
//  INDEX_WIDTH             5   log2(depth); DEPTH = 1<<INDEX_WIDTH
//  ALMOST_FULL_THRESHOLD   28  almost_full asserts when count >= this value
//  ALMOST_EMPTY_THRESHOLD  4   almost_empty asserts when count <= this value
//  Legal only if 0 < ALMOST_EMPTY_THRESHOLD < ALMOST_FULL_THRESHOLD < DEPTH.
//  Any other combination is an elaboration error ($error in a generate block).
// PORTS
//  clk           in   1              clock, rising edge
//  rst_n         in   1              synchronous, active-low reset
//  flush         in   1              synchronous clear of contents and flags
//  wr_en         in   1              push request
//  wr_data       in   DATA_WIDTH     push data
//  rd_en         in   1              pop request / acknowledge
//  rd_data       out  DATA_WIDTH     pop data
//  rd_valid      out  1              rd_data is valid (meaning depends on mode)
//  count         out  INDEX_WIDTH+1  occupancy, 0..DEPTH
//  full          out  1              count == DEPTH
//  empty         out  1              count == 0
//  almost_full   out  1              count >= ALMOST_FULL_THRESHOLD
//  almost_empty  out  1              count <= ALMOST_EMPTY_THRESHOLD
//  overflow      out  1              sticky: a push was refused
//  underflow     out  1              sticky: a pop was refused
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): pointers=0, count=0, rd_data=0, rd_valid=0,
//    overflow=0, underflow=0. Flags follow: empty=1, almost_empty=1, full=0, almost_full=0.
//  pop_ok  = rd_en & ~empty.
//  push_ok = wr_en & (~full | pop_ok). Push on full is accepted when a pop is accepted in the same cycle.
//  Pointers are INDEX_WIDTH bits and wrap modulo DEPTH. count += push_ok - pop_ok, never past 0 or DEPTH.
//  Status flags are combinational decodes of the registered count; they update the cycle after the accepted op.
//  overflow  <= overflow  | (wr_en & ~push_ok). underflow <= underflow | (rd_en & empty).
//  Refused operations change neither data nor pointers.
//  Push and pop on empty: the pop is refused (underflow=1) and the push is accepted (count 0->1).
//  flush=1: same effect as reset on pointers, count, rd_valid and flags. Has priority over wr_en/rd_en in that cycle.
//    rd_data holds its value. Memory contents are not cleared.
//  Reset or flush mid-stream discards all queued entries; the next push lands at index 0.
//  Precedence: rst_n > flush > push/pop.
// CONFIGURATION
//  FIFO_FLEX_FWFT_EN undefined (registered read):
//    rd_data <= mem[rd_ptr] on pop_ok, otherwise it holds.
//    rd_valid is a 1-cycle pulse, registered 1 cycle after pop_ok. Read latency = 1 clk.
//  FIFO_FLEX_FWFT_EN defined (first-word fall-through):
//    rd_data = mem[rd_ptr] combinationally; value is don't-care while empty.
//    rd_valid = ~empty. rd_en acts as acknowledge and advances the head. Read latency = 0.
//  Flags, count and error logic are identical in both modes.
// STRUCTURE
//  fifo_pkg: localparam helpers (clog2 of depth), count/pointer width function, error-bit index constants.
//  fifo_flex_mem: sub-module, DEPTH x DATA_WIDTH register array.
//    One synchronous write port (we, waddr, wdata) and one asynchronous read port (raddr -> rdata).
//  fifo_flex holds the pointers, count, flags, error bits and the read-mode generate.
// TESTING (DATA_WIDTH=8, INDEX_WIDTH=5, both macro settings)
//  1. Reset, then push 0x01..0x20 (32 pushes) -> full=1, count=32, almost_full from count 28.
//     Then pop 32 -> data 0x01..0x20 in order, empty=1, no error flags.
//  2. Full, then push 0xAA alone -> overflow=1, count stays 32.
//     Then push 0xBB with pop the same cycle -> count 32; 0xBB is read last.
//  3. Empty, then pop -> underflow=1, rd_valid=0. Push+pop the same cycle -> count=1, underflow stays 1.
//  4. 100 pushes/pops interleaved at random with occupancy kept 1..31 (pointer wrap exercised)
//     -> output matches scoreboard, count matches model every cycle.
//  5. 10 entries queued, flush with wr_en=1 -> count=0, empty=1, errors cleared, push ignored.
//     Next push 0x5C is read back first.
//  6. Registered mode: pop at cycle N -> rd_valid=1 and rd_data valid at N+1.
//     FWFT mode: first push at N -> rd_valid=1 with that data at N+1.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared helpers for the flexible FIFO: width/depth arithmetic and the
// bit positions of the sticky error vector.
package fifo_pkg;

   localparam int ERR_OVF  = 0;
   localparam int ERR_UDF  = 1;
   localparam int ERR_BITS = 2;

   function automatic int fifo_depth(input int index_width);
      return 1 << index_width;
   endfunction

   // Occupancy must represent 0..DEPTH inclusive, hence one bit wider than a pointer.
   function automatic int count_width(input int index_width);
      return index_width + 1;
   endfunction

   function automatic int clog2_depth(input int depth);
      int w;
      w = 0;
      while ((1 << w) < depth) w++;
      return w;
   endfunction

endpackage

// File: rtl/fifo_flex_mem.sv
// Storage array for fifo_flex: one synchronous write port and one
// asynchronous read port. Contents are intentionally never cleared.
module fifo_flex_mem
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH  = 8,
   parameter int INDEX_WIDTH = 5
) (
   input  logic                   clk,
   input  logic                   we,
   input  logic [INDEX_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0]  wdata,
   input  logic [INDEX_WIDTH-1:0] raddr,
   output logic [DATA_WIDTH-1:0]  rdata
);

   localparam int DEPTH = fifo_depth(INDEX_WIDTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_flex.sv
// Parametrised synchronous FIFO with occupancy count, threshold flags, sticky
// overflow/underflow and flush. FIFO_FLEX_FWFT_EN selects first-word fall-through.
module fifo_flex
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH             = 8,
   parameter int INDEX_WIDTH            = 5,
   parameter int ALMOST_FULL_THRESHOLD  = 28,
   parameter int ALMOST_EMPTY_THRESHOLD = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic                     wr_en,
   input  logic [DATA_WIDTH-1:0]    wr_data,
   input  logic                     rd_en,
   output logic [DATA_WIDTH-1:0]    rd_data,
   output logic                     rd_valid,
   output logic [INDEX_WIDTH:0]     count,
   output logic                     full,
   output logic                     empty,
   output logic                     almost_full,
   output logic                     almost_empty,
   output logic                     overflow,
   output logic                     underflow
);

   localparam int DEPTH = fifo_depth(INDEX_WIDTH);
   localparam int CW    = count_width(INDEX_WIDTH);

   generate
      if (!(ALMOST_EMPTY_THRESHOLD > 0 &&
            ALMOST_EMPTY_THRESHOLD < ALMOST_FULL_THRESHOLD &&
            ALMOST_FULL_THRESHOLD < DEPTH)) begin : g_bad_thresholds
         $error("fifo_flex: thresholds must satisfy 0 < AE < AF < DEPTH");
      end
   endgenerate

   logic [INDEX_WIDTH-1:0] wr_ptr;
   logic [INDEX_WIDTH-1:0] rd_ptr;
   logic [CW-1:0]          count_q;
   logic [ERR_BITS-1:0]    err_q;
   logic                   pop_ok;
   logic                   push_ok;
   logic                   mem_we;
   logic [DATA_WIDTH-1:0]  mem_rdata;

   assign empty        = (count_q == '0);
   assign full         = (count_q == CW'(DEPTH));
   assign almost_full  = (count_q >= CW'(ALMOST_FULL_THRESHOLD));
   assign almost_empty = (count_q <= CW'(ALMOST_EMPTY_THRESHOLD));
   assign count        = count_q;
   assign overflow     = err_q[ERR_OVF];
   assign underflow    = err_q[ERR_UDF];

   // A pop frees a slot in the same cycle, so a full FIFO still takes a concurrent push.
   assign pop_ok  = rd_en & ~empty;
   assign push_ok = wr_en & (~full | pop_ok);
   assign mem_we  = push_ok & rst_n & ~flush;

   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
         err_q   <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         count_q        <= count_q + CW'(push_ok) - CW'(pop_ok);
         err_q[ERR_OVF] <= err_q[ERR_OVF] | (wr_en & ~push_ok);
         err_q[ERR_UDF] <= err_q[ERR_UDF] | (rd_en & empty);
      end
   end

   fifo_flex_mem #(
      .DATA_WIDTH  (DATA_WIDTH),
      .INDEX_WIDTH (INDEX_WIDTH)
   ) u_mem (
      .clk   (clk),
      .we    (mem_we),
      .waddr (wr_ptr),
      .wdata (wr_data),
      .raddr (rd_ptr),
      .rdata (mem_rdata)
   );

`ifdef FIFO_FLEX_FWFT_EN
   // Head entry is always presented; rd_en only acknowledges it.
   assign rd_data  = mem_rdata;
   assign rd_valid = ~empty;
`else
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_data  <= '0;
         rd_valid <= 1'b0;
      end else if (flush) begin
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= pop_ok;
         if (pop_ok) rd_data <= mem_rdata;
      end
   end
`endif

endmodule

// File: tb/tb_fifo_flex.sv
// Self-checking bench for fifo_flex: directed and random steps compared against
// a queue-based reference model; works with or without FIFO_FLEX_FWFT_EN.
module tb_fifo_flex;

   localparam int DW    = 8;
   localparam int IW    = 5;
   localparam int DEPTH = 32;
   localparam int AF    = 28;
   localparam int AE    = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          flush = 1'b0;
   logic          wr_en = 1'b0;
   logic [DW-1:0] wr_data = '0;
   logic          rd_en = 1'b0;
   logic [DW-1:0] rd_data;
   logic          rd_valid;
   logic [IW:0]   count;
   logic          full, empty, almost_full, almost_empty, overflow, underflow;

   int n_tests = 0;
   int n_fail  = 0;

   logic [DW-1:0] q[$];
   bit            m_ovf = 0;
   bit            m_udf = 0;
   bit            exp_valid = 0;
   logic [DW-1:0] exp_data = '0;

   always #5 clk = ~clk;

   fifo_flex #(
      .DATA_WIDTH             (DW),
      .INDEX_WIDTH            (IW),
      .ALMOST_FULL_THRESHOLD  (AF),
      .ALMOST_EMPTY_THRESHOLD (AE)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .flush        (flush),
      .wr_en        (wr_en),
      .wr_data      (wr_data),
      .rd_en        (rd_en),
      .rd_data      (rd_data),
      .rd_valid     (rd_valid),
      .count        (count),
      .full         (full),
      .empty        (empty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .overflow     (overflow),
      .underflow    (underflow)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      int sz;
      sz = q.size();
      chk({tag, ".count"}, 32'(count), 32'(sz));
      chk({tag, ".full"}, 32'(full), 32'(sz == DEPTH));
      chk({tag, ".empty"}, 32'(empty), 32'(sz == 0));
      chk({tag, ".almost_full"}, 32'(almost_full), 32'(sz >= AF));
      chk({tag, ".almost_empty"}, 32'(almost_empty), 32'(sz <= AE));
      chk({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
      chk({tag, ".underflow"}, 32'(underflow), 32'(m_udf));
`ifdef FIFO_FLEX_FWFT_EN
      chk({tag, ".rd_valid"}, 32'(rd_valid), 32'(sz != 0));
      if (sz != 0) chk({tag, ".rd_data"}, 32'(rd_data), 32'(q[0]));
`else
      chk({tag, ".rd_valid"}, 32'(rd_valid), 32'(exp_valid));
      chk({tag, ".rd_data"}, 32'(rd_data), 32'(exp_data));
`endif
   endtask

   // One clock: drive inputs, advance the model by the FIFO's rules, check after the edge.
   task automatic step(input string tag, input bit wr, input logic [DW-1:0] wd,
                       input bit rd, input bit fl);
      bit m_empty, m_full, pop, push;
      wr_en = wr; wr_data = wd; rd_en = rd; flush = fl;
      if (fl) begin
         q.delete();
         m_ovf = 0; m_udf = 0; exp_valid = 0;
      end else begin
         m_empty = (q.size() == 0);
         m_full  = (q.size() == DEPTH);
         pop  = rd && !m_empty;
         push = wr && (!m_full || pop);
         if (rd && m_empty) m_udf = 1;
         if (wr && !push)   m_ovf = 1;
         if (pop) exp_data = q.pop_front();
         exp_valid = pop;
         if (push) q.push_back(wd);
      end
      @(posedge clk); #1;
      wr_en = 0; rd_en = 0; flush = 0;
      check_all(tag);
   endtask

   task automatic do_reset();
      rst_n = 0; wr_en = 0; rd_en = 0; flush = 0;
      @(posedge clk); #1;
      rst_n = 1;
      q.delete();
      m_ovf = 0; m_udf = 0; exp_valid = 0; exp_data = '0;
      check_all("reset");
   endtask

   initial begin
      // 1: fill to full, drain in order
      do_reset();
      for (int i = 1; i <= 32; i++) step("fill", 1, DW'(i), 0, 0);
      chk("fill.full_end", 32'(full), 32'd1);
      for (int i = 0; i < 32; i++) step("drain", 0, 8'h00, 1, 0);
      chk("drain.last", 32'(exp_data), 32'h20);
      chk("drain.no_err", 32'({overflow, underflow}), 32'd0);

      // 2: overflow on full, then push+pop on full
      for (int i = 0; i < 32; i++) step("refill", 1, DW'(8'h40 + i), 0, 0);
      step("ovf", 1, 8'hAA, 0, 0);
      step("push_pop_full", 1, 8'hBB, 1, 0);
      for (int i = 0; i < 32; i++) step("drain2", 0, 8'h00, 1, 0);
      chk("drain2.bb_last", 32'(exp_data), 32'hBB);

      // 3: underflow on empty, then push+pop on empty
      step("udf", 0, 8'h00, 1, 0);
      step("push_pop_empty", 1, 8'h33, 1, 0);

      // 4: random traffic with occupancy kept within 1..31
      for (int i = 0; i < 5; i++) step("prime", 1, DW'($urandom), 0, 0);
      for (int i = 0; i < 100; i++) begin
         bit w, r;
         w = 1'($urandom); r = 1'($urandom);
         if (q.size() <= 1)       begin w = 1; r = 0; end
         else if (q.size() >= 31) begin w = 0; r = 1; end
         step("random", w, DW'($urandom), r, 0);
      end

      // 5: flush with a concurrent push; flush wins
      while (q.size() > 0) step("empty_out", 0, 8'h00, 1, 0);
      for (int i = 0; i < 10; i++) step("queue10", 1, DW'(8'hC0 + i), 0, 0);
      step("flush", 1, 8'hEE, 0, 1);
      step("post_flush_push", 1, 8'h5C, 0, 0);
      step("post_flush_pop", 0, 8'h00, 1, 0);
      chk("flush.first_read", 32'(exp_data), 32'h5C);

      // 6: read latency in the selected mode
      step("lat_push", 1, 8'h77, 0, 0);
      step("lat_pop", 0, 8'h00, 1, 0);
      step("lat_idle", 0, 8'h00, 0, 0);

      // reset mid-stream discards entries; next push lands at index 0
      for (int i = 0; i < 3; i++) step("pre_reset", 1, DW'(8'h90 + i), 0, 0);
      do_reset();
      step("post_reset_push", 1, 8'h11, 0, 0);
      step("post_reset_pop", 0, 8'h00, 1, 0);
      chk("reset.first_read", 32'(exp_data), 32'h11);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
